// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: ALU opcode encodings, the
// ALU pipeline depth, and the tag carried alongside each op while the ALU
// computes its result.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_SHR  = 4'd13;
    localparam logic [3:0] OP_RROT = 4'd14;
    localparam logic [3:0] OP_LROT = 4'd15;

    localparam int ALU_LAT = 2;

    // Tag ids are sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                div0;
    } tag_t;

    // A divide whose divisor is zero never reaches the ALU as such.
    function automatic logic is_div0(input logic [3:0] op, input logic [7:0] b);
        return (op == OP_DIV) && (b == 8'd0);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts just above the
// pointer and wraps, so the requester granted last has lowest priority.
// Ports:
//   req     - request vector, one bit per requester
//   pointer - id of the most recent winner (register kept by the parent)
//   grant   - one-hot grant, all zero when nothing requests
//   winner  - encoded id of the granted requester (0 when none)
//   any     - some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] pointer,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    // Two passes: first the ids above the pointer, then the wrapped-around
    // ids up to and including the pointer itself.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i > int'(pointer))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                winner   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i <= int'(pointer))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                winner   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one pipelined 8-bit ALU among NREQ requesters. At most one op is
// accepted per cycle (round-robin); its operands are registered onto the ALU
// inputs and a tag follows the op down a shift register so the result can
// be steered back to its originator ALU_LAT+1 cycles after acceptance.
// Ports:
//   clk, en                 - clock; en is the asynchronous active-high reset
//   req_valid/ready         - per-requester handshake, ready is one-hot
//   req_a/req_b/req_op      - packed per-requester operands and opcode
//   alu_a/alu_b/alu_s       - registered ALU inputs
//   alu_y/carry/zero        - ALU outputs, valid ALU_LAT edges after inputs
//   rsp_valid/y/carry/zero  - one-hot response strobe and result
//   rsp_err                 - op was a divide by zero
//   ops_issued              - saturating count of accepted ops
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*8-1:0]  req_a,
    input  logic [NREQ*8-1:0]  req_b,
    input  logic [NREQ*4-1:0]  req_op,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_s,
    input  logic [15:0]        alu_y,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [15:0]        rsp_y,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [CNT_W-1:0]   ops_issued
);

    import alu_pkg::*;

    localparam int              ID_W    = $clog2(NREQ);
    localparam int              NSTG    = ALU_LAT + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ID_W-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] winner;
    logic            any_grant;

    logic [7:0]      win_a;
    logic [7:0]      win_b;
    logic [3:0]      win_op;
    logic            win_div0;

    tag_t            tag_pipe [NSTG];
    tag_t            tag_last;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .pointer (rr_ptr),
        .grant   (grant),
        .winner  (winner),
        .any     (any_grant)
    );

    assign req_ready = grant;

    // Select the granted requester's operands; the grant is one-hot so an
    // OR-style mux is enough.
    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_a  = req_a[8*i +: 8];
                win_b  = req_b[8*i +: 8];
                win_op = req_op[4*i +: 4];
            end
        end
        win_div0 = is_div0(win_op, win_b);
    end

    // Issue stage: ALU input registers, RR pointer, tag shift register and
    // the op counter. A divide by zero is sent with b=1 so the ALU never
    // sees a zero divisor; its result is discarded on the way back. Idle
    // cycles drive zeros so the ALU inputs are always defined.
    always_ff @(posedge clk or posedge en) begin
        if (en) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            rr_ptr     <= ID_W'(NREQ - 1);
            ops_issued <= '0;
            for (int i = 0; i < NSTG; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= any_grant;
            tag_pipe[0].id    <= TAG_ID_W'(winner);
            tag_pipe[0].div0  <= any_grant && win_div0;
            for (int i = 1; i < NSTG; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (any_grant) begin
                alu_a  <= win_a;
                alu_b  <= win_div0 ? 8'd1 : win_b;
                alu_s  <= win_op;
                rr_ptr <= winner;
                if (ops_issued != CNT_MAX) begin
                    ops_issued <= ops_issued + CNT_W'(1);
                end
            end else begin
                alu_a <= '0;
                alu_b <= '0;
                alu_s <= '0;
            end
        end
    end

    assign tag_last = tag_pipe[NSTG-1];

    // The oldest tag lines up with the ALU output; steer the result to the
    // tagged requester, forcing the divide-by-zero response.
    always_comb begin
        rsp_valid = '0;
        rsp_y     = '0;
        rsp_carry = 1'b0;
        rsp_zero  = 1'b0;
        rsp_err   = 1'b0;
        if (tag_last.valid) begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_valid[i] = (tag_last.id == TAG_ID_W'(i));
            end
            if (tag_last.div0) begin
                rsp_err = 1'b1;
            end else begin
                rsp_y     = alu_y;
                rsp_carry = alu_carry;
                rsp_zero  = alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a behavioural ALU sits on the ALU
// port, per-requester op queues drive the request side, and a scoreboard of
// expected responses is drained by an independent monitor.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int LAT   = 3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } op_t;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] y;
        logic        c;
        logic        z;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              en  = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a  = '0;
    logic [NREQ*8-1:0] req_b  = '0;
    logic [NREQ*4-1:0] req_op = '0;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_s;
    logic [15:0]       alu_y;
    logic              alu_carry;
    logic              alu_zero;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_y;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              rsp_err;
    logic [CNT_W-1:0]  ops_issued;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    op_t  pend_q [NREQ][$];
    exp_t sb[$];
    int   grant_log[$];
    int   mdl_ptr;
    int   mdl_cnt;
    int   rsp_count = 0;
    logic [7:0]  exp_alu_a;
    logic [7:0]  exp_alu_b;
    logic [3:0]  exp_alu_s;
    logic [15:0] last_rsp_y;
    logic        last_rsp_err;
    logic [NREQ-1:0] last_rsp_valid;

    logic [17:0] alu_p1;
    logic [17:0] alu_p2;

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_y      (alu_y),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .ops_issued (ops_issued)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {carry, zero, y[15:0]}.
    function automatic logic [17:0] aluRef(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  t;
        logic [15:0] y;
        logic        c;
        t = '0;
        y = '0;
        c = 1'b0;
        case (op)
            4'd0:  begin t = {1'b0, a} + {1'b0, b}; y = {7'd0, t}; c = t[8]; end
            4'd1:  begin t = {1'b0, a} - {1'b0, b}; y = {8'd0, t[7:0]}; c = (a < b); end
            4'd2:  begin t = {1'b0, a} + 9'd1; y = {7'd0, t}; c = t[8]; end
            4'd3:  begin t = {1'b0, a} - 9'd1; y = {8'd0, t[7:0]}; c = (a == 8'd0); end
            4'd4:  y = {8'd0, a} * {8'd0, b};
            4'd5:  y = (b == 8'd0) ? 16'hFFFF : {8'd0, a / b};
            4'd6:  y = {8'd0, a & b};
            4'd7:  y = {8'd0, a | b};
            4'd8:  y = {8'd0, a ^ b};
            4'd9:  y = {8'd0, ~(a & b)};
            4'd10: y = {8'd0, ~(a | b)};
            4'd11: y = {8'd0, ~(a ^ b)};
            4'd12: begin y = {8'd0, a << 1}; c = a[7]; end
            4'd13: begin y = {8'd0, a >> 1}; c = a[0]; end
            4'd14: y = {8'd0, a[0], a[7:1]};
            default: y = {8'd0, a[6:0], a[7]};
        endcase
        return {c, (y == 16'd0), y};
    endfunction

    // Two-edge ALU pipeline, reset by the same net as the arbiter.
    always @(posedge clk or posedge en) begin
        if (en) begin
            alu_p1 <= '0;
            alu_p2 <= '0;
        end else begin
            alu_p1 <= aluRef(alu_s, alu_a, alu_b);
            alu_p2 <= alu_p1;
        end
    end

    assign alu_y     = alu_p2[15:0];
    assign alu_zero  = alu_p2[16];
    assign alu_carry = alu_p2[17];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: present queue heads, check the arbiter at the falling
    // edge, record any acceptance, then step to just after the rising edge.
    task automatic applyStimulus();
        logic [NREQ-1:0] v;
        int              g;
        op_t             o;
        exp_t            e;
        logic [17:0]     r;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i].size() > 0) begin
                o = pend_q[i][0];
                v[i] = 1'b1;
                req_a[8*i +: 8]  = o.a;
                req_b[8*i +: 8]  = o.b;
                req_op[4*i +: 4] = o.op;
            end else begin
                req_a[8*i +: 8]  = 8'($urandom);
                req_b[8*i +: 8]  = 8'($urandom);
                req_op[4*i +: 4] = 4'($urandom);
            end
        end
        req_valid = v;
        @(negedge clk);
        g = rrPick(v, mdl_ptr);
        checkOutput("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("ops_issued", 32'(ops_issued), 32'(mdl_cnt));
        checkOutput("alu_a", 32'(alu_a), 32'(exp_alu_a));
        checkOutput("alu_b", 32'(alu_b), 32'(exp_alu_b));
        checkOutput("alu_s", 32'(alu_s), 32'(exp_alu_s));
        if (g >= 0) begin
            o = pend_q[g].pop_front();
            grant_log.push_back(g);
            e.due = cyc + LAT;
            e.id  = g;
            if (o.op == 4'd5 && o.b == 8'd0) begin
                e.y = 16'd0; e.c = 1'b0; e.z = 1'b0; e.err = 1'b1;
                exp_alu_b = 8'd1;
            end else begin
                r = aluRef(o.op, o.a, o.b);
                e.y = r[15:0]; e.z = r[16]; e.c = r[17]; e.err = 1'b0;
                exp_alu_b = o.b;
            end
            sb.push_back(e);
            exp_alu_a = o.a;
            exp_alu_s = o.op;
            mdl_ptr   = g;
            if (mdl_cnt < (1 << CNT_W) - 1) mdl_cnt++;
        end else begin
            exp_alu_a = '0;
            exp_alu_b = '0;
            exp_alu_s = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        en = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) pend_q[i].delete();
        sb.delete();
        mdl_ptr   = NREQ - 1;
        mdl_cnt   = 0;
        exp_alu_a = '0;
        exp_alu_b = '0;
        exp_alu_s = '0;
        #2;
        checkOutput("reset_state", {5'd0, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_err},
                    32'd0);
        checkOutput("reset_alu_cnt", {12'd0, alu_a, alu_b, alu_s}, 32'd0);
        checkOutput("reset_ops", 32'(ops_issued), 32'd0);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic runUntilIdle(input int budget);
        int  n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            busy = (sb.size() > 0);
            for (int i = 0; i < NREQ; i++) if (pend_q[i].size() > 0) busy = 1'b1;
            if (busy) begin
                applyStimulus();
                n++;
            end
        end
        checkOutput("drain_timeout", 32'(busy), 32'd0);
    endtask

    function automatic op_t mkOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        op_t o;
        o.op = op;
        o.a  = a;
        o.b  = b;
        return o;
    endfunction

    // Monitor: every cycle out of reset, either the oldest expected response
    // is due and must match, or the response port must be idle.
    always @(negedge clk) begin
        exp_t e;
        if (!en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                checkOutput("rsp_y", 32'(rsp_y), 32'(e.y));
                checkOutput("rsp_flags", {29'd0, rsp_carry, rsp_zero, rsp_err},
                            {29'd0, e.c, e.z, e.err});
                rsp_count++;
                last_rsp_y     = rsp_y;
                last_rsp_err   = rsp_err;
                last_rsp_valid = rsp_valid;
            end else begin
                checkOutput("rsp_idle", {5'd0, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_err},
                            32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        @(posedge clk);
        #1;
        doReset();

        // Directed: add, then multiply.
        pend_q[0].push_back(mkOp(4'd0, 8'h12, 8'h34));
        runUntilIdle(20);
        checkOutput("add_y", 32'(last_rsp_y), 32'h0046);
        checkOutput("add_valid", 32'(last_rsp_valid), 32'h1);
        pend_q[1].push_back(mkOp(4'd4, 8'h10, 8'h10));
        runUntilIdle(20);
        checkOutput("mul_y", 32'(last_rsp_y), 32'h0100);
        checkOutput("mul_valid", 32'(last_rsp_valid), 32'h2);

        // All four requesters continuously valid for eight grants.
        doReset();
        grant_log.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                pend_q[i].push_back(mkOp(4'($urandom), 8'($urandom), 8'($urandom | 1)));
        runUntilIdle(30);
        checkOutput("rr_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            checkOutput("rr_order", 32'(grant_log[k]), 32'(k % NREQ));
        checkOutput("ops_after_8", 32'(ops_issued), 32'd8);

        // Divide by zero.
        pend_q[2].push_back(mkOp(4'd5, 8'h40, 8'h00));
        runUntilIdle(20);
        checkOutput("div0_err", 32'(last_rsp_err), 32'd1);
        checkOutput("div0_y", 32'(last_rsp_y), 32'd0);
        checkOutput("div0_valid", 32'(last_rsp_valid), 32'h4);

        // Reset with an op in flight.
        pend_q[3].push_back(mkOp(4'd0, 8'h01, 8'h02));
        applyStimulus();
        base = rsp_count;
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus();
        checkOutput("flush_no_rsp", 32'(rsp_count - base), 32'd0);
        checkOutput("flush_ops", 32'(ops_issued), 32'd0);
        grant_log.delete();
        pend_q[0].push_back(mkOp(4'd6, 8'hF0, 8'h3C));
        pend_q[3].push_back(mkOp(4'd7, 8'h0F, 8'h30));
        runUntilIdle(20);
        checkOutput("post_reset_first", 32'(grant_log[0]), 32'd0);

        // Counter saturation with 17 back-to-back ops.
        doReset();
        base = rsp_count;
        for (int k = 0; k < 17; k++)
            pend_q[0].push_back(mkOp(4'd2, 8'(k), 8'h00));
        runUntilIdle(40);
        checkOutput("sat_ops", 32'(ops_issued), 32'hF);
        checkOutput("sat_rsp_count", 32'(rsp_count - base), 32'd17);

        // Randomized traffic with one reset in the middle.
        doReset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend_q[i].size() < 3 && $urandom_range(2) == 0) begin
                    pend_q[i].push_back(mkOp(4'($urandom),
                                             8'($urandom),
                                             ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom)));
                end
            end
            if (c == 150) doReset();
            else applyStimulus();
        end
        runUntilIdle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
